// File: rtl/sklansky_result_display_if.sv
// Handshake bundle between the adder result source and sklansky_result_display.
// Optional HEX_DISPLAY_EN adds hex_sel, sampled together with load.
interface sklansky_result_display_if;
    logic [7:0] sum;
    logic       cout;
    logic       load;
    logic       busy;
    logic       valid;
`ifdef HEX_DISPLAY_EN
    logic       hex_sel;

    modport master (output sum, cout, load, hex_sel, input busy, valid);
    modport slave  (input sum, cout, load, hex_sel, output busy, valid);
`else
    modport master (output sum, cout, load, input busy, valid);
    modport slave  (input sum, cout, load, output busy, valid);
`endif
endinterface

// File: rtl/sklansky_result_display.sv
// Captures the 9-bit adder result, converts it to BCD by double-dabble and scans it
// onto an active-low 3-digit 7-segment display. Optional feature macro: HEX_DISPLAY_EN.
module sklansky_result_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    sklansky_result_display_if.slave      bus,
    output logic [6:0]                    seg,
    output logic [3:0]                    an
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                 state;
    logic [8:0]             value;
    logic [11:0]            bcd;
    logic [11:0]            disp;
    logic [3:0]             shift_cnt;
    logic [REFRESH_DIV-1:0] refresh_cnt;
    logic [1:0]             digit_idx;
    logic                   busy_r;
    logic                   valid_r;
`ifdef HEX_DISPLAY_EN
    logic                   hex_mode;
`endif

    logic [11:0] adj_bcd;
    logic [11:0] next_bcd;
    logic [8:0]  next_value;
    logic [3:0]  digit_sel;
    logic        blank;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
`ifdef HEX_DISPLAY_EN
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            4'hF:    return 7'b0001110;
`endif
            default: return 7'b1111111;
        endcase
    endfunction

    // In hex mode the add-3 step is skipped, so nine plain shifts leave the raw value as three nibbles.
    always_comb begin
        adj_bcd = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
`ifdef HEX_DISPLAY_EN
        if (hex_mode)
            adj_bcd = bcd;
`endif
        next_bcd   = {adj_bcd[10:0], value[8]};
        next_value = {value[7:0], 1'b0};
    end

    always_comb begin
        case (digit_idx)
            2'd0:    digit_sel = disp[3:0];
            2'd1:    digit_sel = disp[7:4];
            default: digit_sel = disp[11:8];
        endcase
        blank = ((digit_idx == 2'd2) && (disp[11:8] == 4'd0)) ||
                ((digit_idx == 2'd1) && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0));
        seg_next = 7'b1111111;
        an_next  = 4'b1111;
        if (valid_r) begin
            an_next  = ~(4'b0001 << digit_idx);
            seg_next = blank ? 7'b1111111 : seg_code(digit_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            value       <= '0;
            bcd         <= '0;
            disp        <= '0;
            shift_cnt   <= '0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            seg         <= 7'b1111111;
            an          <= 4'b1111;
`ifdef HEX_DISPLAY_EN
            hex_mode    <= 1'b0;
`endif
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_DIV'(1);
            if (refresh_cnt == '1)
                digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
            seg <= seg_next;
            an  <= an_next;

            case (state)
                IDLE: begin
                    if (bus.load) begin
                        value     <= {bus.cout, bus.sum};
                        bcd       <= '0;
                        shift_cnt <= '0;
                        busy_r    <= 1'b1;
                        state     <= CONV;
`ifdef HEX_DISPLAY_EN
                        hex_mode  <= bus.hex_sel;
`endif
                    end
                end
                CONV: begin
                    bcd       <= next_bcd;
                    value     <= next_value;
                    shift_cnt <= shift_cnt + 4'd1;
                    // Ninth shift: commit the whole result at once so no partial digits show.
                    if (shift_cnt == 4'd8) begin
                        disp    <= next_bcd;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_sklansky_result_display.sv
// Directed testbench for sklansky_result_display with REFRESH_DIV=2.
// Define HEX_DISPLAY_EN to also exercise hex mode.
module tb_sklansky_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    sklansky_result_display_if bus();

    sklansky_result_display #(.REFRESH_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .seg (seg),
        .an  (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses load for one edge (E); returns at the falling edge just after E.
    task automatic applyStimulus(input logic [8:0] v, input logic hs);
        @(negedge clk);
        bus.sum  = v[7:0];
        bus.cout = v[8];
`ifdef HEX_DISPLAY_EN
        bus.hex_sel = hs;
`else
        if (hs) $display("[TB] hex_sel requested but not present in this build");
`endif
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic checkConversion(input string tag);
        for (int i = 0; i < 9; i++) begin
            checkOutput({tag, "_busy_hi"}, bus.busy, 1);
            @(negedge clk);
        end
        checkOutput({tag, "_busy_lo"}, bus.busy, 0);
        checkOutput({tag, "_valid"}, bus.valid, 1);
    endtask

    task automatic checkDigit(input string tag, input int pos, input logic [6:0] exp_seg);
        logic [3:0] target;
        int n;
        target = ~(4'b0001 << pos);
        n = 0;
        while (an !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40)
            checkOutput({tag, "_scan_timeout"}, an, target);
        checkOutput({tag, "_seg"}, seg, exp_seg);
    endtask

    initial begin
        rst      = 1'b1;
        bus.sum  = '0;
        bus.cout = 1'b0;
        bus.load = 1'b0;
`ifdef HEX_DISPLAY_EN
        bus.hex_sel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            checkOutput("reset_idle", {bus.busy, bus.valid, an, seg}, {1'b0, 1'b0, 4'b1111, 7'b1111111});
            @(negedge clk);
        end

        // 511: full range
        applyStimulus(9'd511, 1'b0);
        checkOutput("c511_valid_pre", bus.valid, 0);
        checkConversion("c511");
        checkDigit("c511_ones", 0, 7'b1111001);
        checkDigit("c511_tens", 1, 7'b1111001);
        checkDigit("c511_hund", 2, 7'b0010010);

        // 7: tens and hundreds blanked but anodes still scanned
        applyStimulus(9'd7, 1'b0);
        checkOutput("c7_valid_hold", bus.valid, 1);
        checkConversion("c7");
        checkDigit("c7_ones", 0, 7'b1111000);
        checkDigit("c7_tens", 1, 7'b1111111);
        checkDigit("c7_hund", 2, 7'b1111111);

        // 42 with a 99 load attempt at E+4 that must be ignored
        applyStimulus(9'd42, 1'b0);
        repeat (3) @(negedge clk);
        bus.sum  = 8'd99;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("c42_busy_hi", bus.busy, 1);
            @(negedge clk);
        end
        checkOutput("c42_busy_lo", bus.busy, 0);
        @(negedge clk);
        checkOutput("c42_not_queued", bus.busy, 0);
        checkDigit("c42_ones", 0, 7'b0100100);
        checkDigit("c42_tens", 1, 7'b0011001);
        checkDigit("c42_hund", 2, 7'b1111111);

        // 200 aborted by reset at E+5
        applyStimulus(9'd200, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_state", {bus.busy, bus.valid, an, seg}, {1'b0, 1'b0, 4'b1111, 7'b1111111});
        repeat (12) @(negedge clk);
        checkOutput("abort_stays_idle", {bus.busy, bus.valid, an}, {1'b0, 1'b0, 4'b1111});

        // reset and load together: reset wins
        bus.sum  = 8'd9;
        rst      = 1'b1;
        bus.load = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        checkOutput("rst_beats_load", bus.busy, 0);

        applyStimulus(9'd3, 1'b0);
        checkConversion("c3");
        checkDigit("c3_ones", 0, 7'b0110000);
        checkDigit("c3_tens", 1, 7'b1111111);
        checkDigit("c3_hund", 2, 7'b1111111);

        // 100: zero tens kept because hundreds is non-zero
        applyStimulus(9'd100, 1'b0);
        checkConversion("c100");
        checkDigit("c100_ones", 0, 7'b1000000);
        checkDigit("c100_tens", 1, 7'b1000000);
        checkDigit("c100_hund", 2, 7'b1111001);

        // 0: only the ones digit lit
        applyStimulus(9'd0, 1'b0);
        checkConversion("c0");
        checkDigit("c0_ones", 0, 7'b1000000);
        checkDigit("c0_tens", 1, 7'b1111111);
        checkDigit("c0_hund", 2, 7'b1111111);

        // load held high restarts on return to IDLE
        @(negedge clk);
        bus.sum  = 8'd58;
        bus.cout = 1'b0;
        bus.load = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        checkOutput("held_busy_e8", bus.busy, 1);
        @(negedge clk);
        checkOutput("held_busy_e9", bus.busy, 0);
        @(negedge clk);
        checkOutput("held_restart", bus.busy, 1);
        bus.load = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.busy !== 1'b0 && n < 15) begin
                @(negedge clk);
                n++;
            end
            if (n >= 15)
                checkOutput("held_busy_timeout", bus.busy, 0);
        end
        checkDigit("c58_ones", 0, 7'b0000000);
        checkDigit("c58_tens", 1, 7'b0010010);
        checkDigit("c58_hund", 2, 7'b1111111);

`ifdef HEX_DISPLAY_EN
        applyStimulus(9'h1AB, 1'b1);
        checkConversion("h1ab");
        checkDigit("h1ab_ones", 0, 7'b0000011);
        checkDigit("h1ab_tens", 1, 7'b0001000);
        checkDigit("h1ab_hund", 2, 7'b1111001);

        applyStimulus(9'h00F, 1'b1);
        checkConversion("h00f");
        checkDigit("h00f_ones", 0, 7'b0001110);
        checkDigit("h00f_tens", 1, 7'b1111111);
        checkDigit("h00f_hund", 2, 7'b1111111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
